// File: rtl/scu_timers.sv
// SCU timer 0 / timer 1 engine.
// Timer 0 counts HBlank-in events per frame and pulses T0_IRQ when the count
// reaches T0C. Timer 1 reloads from T1S on each HBlank-in and counts CE ticks
// down to an expire pulse on T1_IRQ. In MD=1 mode, timer 1 only arms on the
// line where timer 0 matches.
module scu_timers #(
    parameter int T0_W = 10,
    parameter int T1_W = 9
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            HBLANK,
    input  logic            VBLANK,
    input  logic [7:0]      REG_A,
    input  logic [31:0]     REG_DI,
    input  logic            REG_WE,
    output logic            T0_IRQ,
    output logic            T1_IRQ,
    output logic [T0_W-1:0] T0_CNT
);

    // Word offsets of the timer registers (byte offset >> 2)
    localparam logic [5:0] A_T0C  = 6'h24;  // 0x90
    localparam logic [5:0] A_T1S  = 6'h25;  // 0x94
    localparam logic [5:0] A_T1MD = 6'h26;  // 0x98

    logic [T0_W-1:0] t0c;
    logic [T1_W-1:0] t1s;
    logic            md, enb;
    logic            hb_d, vb_d;
    logic [T1_W-1:0] t1_cnt;
    logic            armed;

    logic            hb_rise, vb_fall;
    logic [T0_W-1:0] t0_next;
    logic            t0_hit;
    logic            wr_t0c, wr_t1s, wr_md, enb_clr;

    // Byte-lane bits of the address and high data bits are not decoded
    logic unused_bits;
    assign unused_bits = &{1'b0, REG_A[1:0], REG_DI[31:T0_W]};

    assign wr_t0c  = REG_WE && (REG_A[7:2] == A_T0C);
    assign wr_t1s  = REG_WE && (REG_A[7:2] == A_T1S);
    assign wr_md   = REG_WE && (REG_A[7:2] == A_T1MD);
    assign enb_clr = wr_md && !REG_DI[0];

    assign hb_rise = HBLANK & ~hb_d;
    assign vb_fall = ~VBLANK & vb_d;

    // VBlank-out clears and wins over a coincident HBlank-in; the add wraps.
    // t0_hit doubles as the per-line match flag: the arm decision consumes
    // it in the same cycle, so no separate line_match register is kept.
    assign t0_next = vb_fall ? '0 : T0_CNT + 1'b1;
    assign t0_hit  = (vb_fall | hb_rise) && (t0_next == t0c);

    // Registers, edge history, timer 0 count/match and timer 1 load/countdown
    always_ff @(posedge CLK) begin
        if (RST) begin
            t0c    <= '0;
            t1s    <= '0;
            md     <= 1'b0;
            enb    <= 1'b0;
            hb_d   <= 1'b0;
            vb_d   <= 1'b0;
            T0_CNT <= '0;
            T0_IRQ <= 1'b0;
            T1_IRQ <= 1'b0;
            t1_cnt <= '0;
            armed  <= 1'b0;
        end else begin
            hb_d <= HBLANK;
            vb_d <= VBLANK;

            if (wr_t0c) t0c <= REG_DI[T0_W-1:0];
            if (wr_t1s) t1s <= REG_DI[T1_W-1:0];
            if (wr_md) begin
                md  <= REG_DI[8];
                enb <= REG_DI[0];
            end

            if (vb_fall | hb_rise) T0_CNT <= t0_next;
            T0_IRQ <= t0_hit & enb;

            T1_IRQ <= 1'b0;
            if (hb_rise) begin
                // A reload also silently discards an unexpired countdown
                t1_cnt <= t1s;
                armed  <= enb & (~md | t0_hit);
            end else if (CE && armed) begin
                if (t1_cnt <= T1_W'(1)) begin
                    T1_IRQ <= ~enb_clr;
                    armed  <= 1'b0;
                    t1_cnt <= '0;
                end else begin
                    t1_cnt <= t1_cnt - 1'b1;
                end
            end

            // Disabling drops any pending countdown immediately
            if (enb_clr) armed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scu_timers.sv
// Directed bench for scu_timers: timer 0 count/match, timer 1 load/expire,
// MD line-gated mode, reload without expire, reset and write masking.
module tb_scu_timers;

    logic        CLK = 1'b0;
    logic        RST, CE, HBLANK, VBLANK, REG_WE;
    logic [7:0]  REG_A;
    logic [31:0] REG_DI;
    logic        T0_IRQ, T1_IRQ;
    logic [9:0]  T0_CNT;

    int errors = 0;
    int checks = 0;
    int n_pulse;
    int fire_idx;
    logic fired;

    scu_timers dut (
        .CLK(CLK), .RST(RST), .CE(CE), .HBLANK(HBLANK), .VBLANK(VBLANK),
        .REG_A(REG_A), .REG_DI(REG_DI), .REG_WE(REG_WE),
        .T0_IRQ(T0_IRQ), .T1_IRQ(T1_IRQ), .T0_CNT(T0_CNT)
    );

    always #5 CLK = ~CLK;

    // One clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        REG_A = a; REG_DI = d; REG_WE = 1'b1;
        step();
        REG_WE = 1'b0; REG_A = 8'h00; REG_DI = 32'h0;
    endtask

    // VBlank high then low: the falling edge clears timer 0
    task automatic vfall(output logic irq);
        VBLANK = 1'b1; step();
        VBLANK = 1'b0; step();
        irq = T0_IRQ;
    endtask

    // One HBlank-in; returns T0_IRQ seen right after the edge cycle
    task automatic hline(output logic irq);
        HBLANK = 1'b1; step();
        irq = T0_IRQ;
        HBLANK = 1'b0; step();
    endtask

    // Three idle clocks then a CE strobe; returns T1_IRQ after the strobe
    task automatic tick(output logic irq);
        CE = 1'b0;
        repeat (3) step();
        CE = 1'b1; step();
        CE = 1'b0;
        irq = T1_IRQ;
    endtask

    initial begin
        RST = 1'b1; CE = 1'b0; HBLANK = 1'b0; VBLANK = 1'b0;
        REG_WE = 1'b0; REG_A = 8'h00; REG_DI = 32'h0;
        step(); step();
        RST = 1'b0;
        chk("reset_t0cnt", 32'(T0_CNT), 32'd0);
        chk("reset_t0irq", 32'(T0_IRQ), 32'd0);
        chk("reset_t1irq", 32'(T1_IRQ), 32'd0);

        // 1: T0C=5, six lines after VBlank-out -> one pulse on the 5th
        wr(8'h90, 32'd5);
        wr(8'h98, 32'h1);
        vfall(fired);
        chk("t1_vfall_cnt", 32'(T0_CNT), 32'd0);
        n_pulse = 0;
        for (int i = 1; i <= 6; i++) begin
            hline(fired);
            if (fired) n_pulse++;
            if (i == 5) chk("t1_irq_on_5th", 32'(fired), 32'd1);
            if (i == 5) chk("t1_irq_one_cycle", 32'(T0_IRQ), 32'd0);
        end
        chk("t1_pulse_count", n_pulse, 1);
        chk("t1_cnt_after_6", 32'(T0_CNT), 32'd6);

        // 2: T0C=0, VBlank-out coincident with HBlank-in -> clear wins, match
        wr(8'h90, 32'd0);
        VBLANK = 1'b1; step();
        VBLANK = 1'b0; HBLANK = 1'b1; step();
        chk("t2_cnt_cleared", 32'(T0_CNT), 32'd0);
        chk("t2_irq", 32'(T0_IRQ), 32'd1);
        HBLANK = 1'b0; step();
        chk("t2_irq_drop", 32'(T0_IRQ), 32'd0);

        // 3: MD=0, T1S=3 -> fires on 3rd CE each line; none when disabled
        wr(8'h94, 32'd3);
        for (int ln = 0; ln < 2; ln++) begin
            hline(fired);
            for (int k = 1; k <= 4; k++) begin
                tick(fired);
                chk($sformatf("t3_line%0d_ce%0d", ln, k), 32'(fired), (k == 3) ? 32'd1 : 32'd0);
            end
        end
        wr(8'h98, 32'h0);
        hline(fired);
        n_pulse = 0;
        for (int k = 1; k <= 4; k++) begin
            tick(fired);
            if (fired) n_pulse++;
        end
        chk("t3_disabled_none", n_pulse, 0);

        // 4: MD=1, T0C=2, T1S=1 -> only line 2 fires
        wr(8'h98, 32'h101);
        wr(8'h90, 32'd2);
        wr(8'h94, 32'd1);
        vfall(fired);
        for (int ln = 1; ln <= 3; ln++) begin
            hline(fired);
            chk($sformatf("t4_t0irq_line%0d", ln), 32'(fired), (ln == 2) ? 32'd1 : 32'd0);
            tick(fired);
            chk($sformatf("t4_t1irq_line%0d", ln), 32'(fired), (ln == 2) ? 32'd1 : 32'd0);
        end

        // 5: T1S=100 with lines every 20 CE -> never expires; then full count
        wr(8'h98, 32'h1);
        wr(8'h94, 32'd100);
        n_pulse = 0;
        for (int ln = 0; ln < 3; ln++) begin
            hline(fired);
            for (int k = 0; k < 20; k++) begin
                tick(fired);
                if (fired) n_pulse++;
            end
        end
        chk("t5_no_expire", n_pulse, 0);
        hline(fired);
        n_pulse = 0; fire_idx = 0;
        for (int k = 1; k <= 101; k++) begin
            tick(fired);
            if (fired) begin n_pulse++; fire_idx = k; end
        end
        chk("t5_full_count_once", n_pulse, 1);
        chk("t5_full_count_at100", fire_idx, 100);

        // 6: reset while armed with t1_cnt=2 cancels; defaults then apply
        wr(8'h94, 32'd3);
        hline(fired);
        tick(fired);
        RST = 1'b1; step();
        RST = 1'b0;
        chk("t6_rst_t1irq", 32'(T1_IRQ), 32'd0);
        chk("t6_rst_t0cnt", 32'(T0_CNT), 32'd0);
        n_pulse = 0;
        for (int k = 0; k < 3; k++) begin
            tick(fired);
            if (fired) n_pulse++;
        end
        chk("t6_armed_cancelled", n_pulse, 0);
        wr(8'h98, 32'h1);
        vfall(fired);
        chk("t6_t0c_reset_zero", 32'(fired), 32'd1);
        hline(fired);
        tick(fired);
        chk("t6_t1s_reset_zero", 32'(fired), 32'd1);

        // Write masking: 0xFFFFFFFF to T0C -> match at count 0x3FF, then wrap
        wr(8'h90, 32'hFFFF_FFFF);
        vfall(fired);
        n_pulse = 0;
        for (int i = 1; i <= 1023; i++) begin
            hline(fired);
            if (fired) n_pulse++;
        end
        chk("t6_mask_last_irq", 32'(fired), 32'd1);
        chk("t6_mask_pulses", n_pulse, 1);
        chk("t6_mask_cnt", 32'(T0_CNT), 32'h3FF);
        hline(fired);
        chk("t6_wrap_cnt", 32'(T0_CNT), 32'd0);
        chk("t6_wrap_no_irq", 32'(fired), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
